// File: rtl/id_operand_fetch_if.sv
// Bus bundle for the operand-fetch stage: ID inputs, RF read port,
// EX/MEM/WB forwarding taps, stall/flush control and the ID/EX slot.
interface id_operand_fetch_if #(
  parameter int DW     = 32,
  parameter int CTRL_W = 16
);
  logic              id_valid;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [4:0]        id_rd;
  logic              id_we;
  logic [CTRL_W-1:0] id_ctrl;

  logic [4:0]        rR1;
  logic [4:0]        rR2;
  logic [DW-1:0]     rD1;
  logic [DW-1:0]     rD2;

  logic              ex_valid;
  logic              ex_we;
  logic              ex_is_load;
  logic [4:0]        ex_rd;
  logic [DW-1:0]     ex_wd;
  logic              mem_valid;
  logic              mem_we;
  logic [4:0]        mem_rd;
  logic [DW-1:0]     mem_wd;
  logic              wb_valid;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [DW-1:0]     wb_wd;

  logic              flush;
  logic              stall_clr;
  logic              stall;

  logic              idex_valid;
  logic [DW-1:0]     idex_op1;
  logic [DW-1:0]     idex_op2;
  logic [4:0]        idex_rd;
  logic              idex_we;
  logic [CTRL_W-1:0] idex_ctrl;
  logic [31:0]       stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we, id_ctrl,
    output rD1, rD2,
    output ex_valid, ex_we, ex_is_load, ex_rd, ex_wd,
    output mem_valid, mem_we, mem_rd, mem_wd,
    output wb_valid, wb_we, wb_rd, wb_wd,
    output flush, stall_clr,
    input  rR1, rR2, stall,
    input  idex_valid, idex_op1, idex_op2, idex_rd, idex_we, idex_ctrl, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we, id_ctrl,
    input  rD1, rD2,
    input  ex_valid, ex_we, ex_is_load, ex_rd, ex_wd,
    input  mem_valid, mem_we, mem_rd, mem_wd,
    input  wb_valid, wb_we, wb_rd, wb_wd,
    input  flush, stall_clr,
    output rR1, rR2, stall,
    output idex_valid, idex_op1, idex_op2, idex_rd, idex_we, idex_ctrl, stall_cnt
  );
endinterface

// File: rtl/id_operand_fetch.sv
// Operand fetch for the ID stage: RF read addressing, EX/MEM/WB forwarding,
// load-use stall detection and the ID/EX pipeline register.
module id_operand_fetch #(
  parameter int DW     = 32,
  parameter int CTRL_W = 16
) (
  input logic               clk,
  input logic               rst,
  id_operand_fetch_if.slave bus
);

  logic              ex_hit1, mem_hit1, wb_hit1;
  logic              ex_hit2, mem_hit2, wb_hit2;
  logic [DW-1:0]     op1_w, op2_w;
  logic              stall_w;
  logic              load_dst;

  logic              idex_valid_q;
  logic [DW-1:0]     idex_op1_q;
  logic [DW-1:0]     idex_op2_q;
  logic [4:0]        idex_rd_q;
  logic              idex_we_q;
  logic [CTRL_W-1:0] idex_ctrl_q;
  logic [31:0]       stall_cnt_q;

  assign bus.rR1 = bus.id_rs1;
  assign bus.rR2 = bus.id_rs2;

  // EX never forwards a load result; that case is resolved by the stall instead
  assign ex_hit1  = bus.ex_valid & bus.ex_we & ~bus.ex_is_load & (bus.ex_rd == bus.id_rs1);
  assign mem_hit1 = bus.mem_valid & bus.mem_we & (bus.mem_rd == bus.id_rs1);
  assign wb_hit1  = bus.wb_valid & bus.wb_we & (bus.wb_rd == bus.id_rs1);
  assign ex_hit2  = bus.ex_valid & bus.ex_we & ~bus.ex_is_load & (bus.ex_rd == bus.id_rs2);
  assign mem_hit2 = bus.mem_valid & bus.mem_we & (bus.mem_rd == bus.id_rs2);
  assign wb_hit2  = bus.wb_valid & bus.wb_we & (bus.wb_rd == bus.id_rs2);

  // Operand 1 mux: x0 reads zero, then youngest producer wins (EX > MEM > WB > RF)
  always_comb begin
    op1_w = bus.rD1;
    if (bus.id_rs1 == 5'd0) op1_w = '0;
    else if (ex_hit1)       op1_w = bus.ex_wd;
    else if (mem_hit1)      op1_w = bus.mem_wd;
    else if (wb_hit1)       op1_w = bus.wb_wd;
  end

  // Operand 2 mux, same rules as operand 1
  always_comb begin
    op2_w = bus.rD2;
    if (bus.id_rs2 == 5'd0) op2_w = '0;
    else if (ex_hit2)       op2_w = bus.ex_wd;
    else if (mem_hit2)      op2_w = bus.mem_wd;
    else if (wb_hit2)       op2_w = bus.wb_wd;
  end

  // One bubble lets the load reach MEM, where its data becomes forwardable
  assign load_dst = bus.ex_valid & bus.ex_we & bus.ex_is_load & (bus.ex_rd != 5'd0);
  assign stall_w  = bus.id_valid & ~bus.flush & load_dst &
                    ((bus.id_rs1_used & (bus.id_rs1 == bus.ex_rd)) |
                     (bus.id_rs2_used & (bus.id_rs2 == bus.ex_rd)));
  assign bus.stall = stall_w;

  // ID/EX slot: flush or stall insert a fully zeroed bubble, otherwise capture ID
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_valid_q <= 1'b0;
      idex_op1_q   <= '0;
      idex_op2_q   <= '0;
      idex_rd_q    <= '0;
      idex_we_q    <= 1'b0;
      idex_ctrl_q  <= '0;
    end else if (bus.flush || stall_w) begin
      idex_valid_q <= 1'b0;
      idex_op1_q   <= '0;
      idex_op2_q   <= '0;
      idex_rd_q    <= '0;
      idex_we_q    <= 1'b0;
      idex_ctrl_q  <= '0;
    end else begin
      idex_valid_q <= bus.id_valid;
      idex_op1_q   <= op1_w;
      idex_op2_q   <= op2_w;
      idex_rd_q    <= bus.id_rd;
      idex_we_q    <= bus.id_we & bus.id_valid;
      idex_ctrl_q  <= bus.id_ctrl;
    end
  end

  // Saturating stall-cycle counter; clear wins over counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (bus.stall_clr) begin
      stall_cnt_q <= '0;
    end else if (stall_w && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.idex_valid = idex_valid_q;
  assign bus.idex_op1   = idex_op1_q;
  assign bus.idex_op2   = idex_op2_q;
  assign bus.idex_rd    = idex_rd_q;
  assign bus.idex_we    = idex_we_q;
  assign bus.idex_ctrl  = idex_ctrl_q;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_id_operand_fetch.sv
// Scoreboard bench for id_operand_fetch: a driver applies one stimulus per
// cycle and queues the reference result; a monitor pops and compares.
module tb_id_operand_fetch;

  localparam int DW     = 32;
  localparam int CTRL_W = 16;

  typedef struct {
    logic              id_valid;
    logic [4:0]        rs1, rs2;
    logic              u1, u2;
    logic [4:0]        rd;
    logic              we;
    logic [CTRL_W-1:0] ctrl;
    logic [DW-1:0]     rd1, rd2;
    logic              ex_valid, ex_we, ex_ld;
    logic [4:0]        ex_rd;
    logic [DW-1:0]     ex_wd;
    logic              mem_valid, mem_we;
    logic [4:0]        mem_rd;
    logic [DW-1:0]     mem_wd;
    logic              wb_valid, wb_we;
    logic [4:0]        wb_rd;
    logic [DW-1:0]     wb_wd;
    logic              flush, clr;
  } stim_t;

  typedef struct {
    logic              stall;
    logic [4:0]        rr1, rr2;
    logic              v;
    logic [DW-1:0]     op1, op2;
    logic [4:0]        rd;
    logic              we;
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t expq[$];
  logic [31:0] m_cnt = '0;

  id_operand_fetch_if #(.DW(DW), .CTRL_W(CTRL_W)) bus ();

  id_operand_fetch #(.DW(DW), .CTRL_W(CTRL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Architectural value a source register should read, given in-flight writers
  function automatic logic [DW-1:0] ref_operand(input stim_t s, input logic [4:0] rs,
                                                input logic [DW-1:0] rf);
    if (rs == 0) return '0;
    if (s.ex_valid && s.ex_we && !s.ex_ld && s.ex_rd == rs) return s.ex_wd;
    if (s.mem_valid && s.mem_we && s.mem_rd == rs) return s.mem_wd;
    if (s.wb_valid && s.wb_we && s.wb_rd == rs) return s.wb_wd;
    return rf;
  endfunction

  function automatic logic ref_stall(input stim_t s);
    if (!s.id_valid || s.flush) return 1'b0;
    if (!(s.ex_valid && s.ex_we && s.ex_ld) || s.ex_rd == 0) return 1'b0;
    return (s.u1 && s.rs1 == s.ex_rd) || (s.u2 && s.rs2 == s.ex_rd);
  endfunction

  function automatic stim_t quiet();
    stim_t s;
    s = '{id_valid:0, rs1:0, rs2:0, u1:0, u2:0, rd:0, we:0, ctrl:0, rd1:0, rd2:0,
          ex_valid:0, ex_we:0, ex_ld:0, ex_rd:0, ex_wd:0,
          mem_valid:0, mem_we:0, mem_rd:0, mem_wd:0,
          wb_valid:0, wb_we:0, wb_rd:0, wb_wd:0, flush:0, clr:0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.id_valid  = ($urandom_range(0, 3) != 0);
    s.rs1       = 5'($urandom_range(0, 7));
    s.rs2       = 5'($urandom_range(0, 7));
    s.u1        = ($urandom_range(0, 3) != 0);
    s.u2        = ($urandom_range(0, 3) != 0);
    s.rd        = 5'($urandom_range(0, 31));
    s.we        = 1'($urandom_range(0, 1));
    s.ctrl      = 16'($urandom);
    s.rd1       = $urandom;
    s.rd2       = $urandom;
    s.ex_valid  = ($urandom_range(0, 3) != 0);
    s.ex_we     = ($urandom_range(0, 3) != 0);
    s.ex_ld     = ($urandom_range(0, 2) == 0);
    s.ex_rd     = 5'($urandom_range(0, 7));
    s.ex_wd     = $urandom;
    s.mem_valid = ($urandom_range(0, 3) != 0);
    s.mem_we    = ($urandom_range(0, 3) != 0);
    s.mem_rd    = 5'($urandom_range(0, 7));
    s.mem_wd    = $urandom;
    s.wb_valid  = ($urandom_range(0, 3) != 0);
    s.wb_we     = ($urandom_range(0, 3) != 0);
    s.wb_rd     = 5'($urandom_range(0, 7));
    s.wb_wd     = $urandom;
    s.flush     = ($urandom_range(0, 7) == 0);
    s.clr       = ($urandom_range(0, 15) == 0);
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.id_valid = s.id_valid;  bus.id_rs1 = s.rs1;  bus.id_rs2 = s.rs2;
    bus.id_rs1_used = s.u1;     bus.id_rs2_used = s.u2;
    bus.id_rd = s.rd;           bus.id_we = s.we;    bus.id_ctrl = s.ctrl;
    bus.rD1 = s.rd1;            bus.rD2 = s.rd2;
    bus.ex_valid = s.ex_valid;  bus.ex_we = s.ex_we; bus.ex_is_load = s.ex_ld;
    bus.ex_rd = s.ex_rd;        bus.ex_wd = s.ex_wd;
    bus.mem_valid = s.mem_valid; bus.mem_we = s.mem_we;
    bus.mem_rd = s.mem_rd;      bus.mem_wd = s.mem_wd;
    bus.wb_valid = s.wb_valid;  bus.wb_we = s.wb_we;
    bus.wb_rd = s.wb_rd;        bus.wb_wd = s.wb_wd;
    bus.flush = s.flush;        bus.stall_clr = s.clr;
  endtask

  // Present one ID cycle and queue what the slot and counter must show after the edge
  task automatic apply(input stim_t s);
    exp_t e;
    @(negedge clk);
    drive(s);
    e.stall = ref_stall(s);
    e.rr1   = s.rs1;
    e.rr2   = s.rs2;
    if (s.flush || e.stall) begin
      e.v = 0; e.op1 = '0; e.op2 = '0; e.rd = '0; e.we = 0; e.ctrl = '0;
    end else begin
      e.v    = s.id_valid;
      e.op1  = ref_operand(s, s.rs1, s.rd1);
      e.op2  = ref_operand(s, s.rs2, s.rd2);
      e.rd   = s.rd;
      e.we   = s.we && s.id_valid;
      e.ctrl = s.ctrl;
    end
    if (s.clr) m_cnt = '0;
    else if (e.stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    e.cnt = m_cnt;
    expq.push_back(e);
  endtask

  // Monitor: combinational outputs late in the cycle, registered outputs after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("stall", 64'(bus.stall), 64'(e.stall));
        chk("rR1", 64'(bus.rR1), 64'(e.rr1));
        chk("rR2", 64'(bus.rR2), 64'(e.rr2));
        @(posedge clk);
        #1;
        chk("idex_valid", 64'(bus.idex_valid), 64'(e.v));
        chk("idex_op1", 64'(bus.idex_op1), 64'(e.op1));
        chk("idex_op2", 64'(bus.idex_op2), 64'(e.op2));
        chk("idex_rd", 64'(bus.idex_rd), 64'(e.rd));
        chk("idex_we", 64'(bus.idex_we), 64'(e.we));
        chk("idex_ctrl", 64'(bus.idex_ctrl), 64'(e.ctrl));
        chk("stall_cnt", 64'(bus.stall_cnt), 64'(e.cnt));
      end
    end
  end

  initial begin
    stim_t s;
    drive(quiet());
    bus.id_valid = 1'b1;
    bus.id_rs1   = 5'd3;
    bus.rD1      = 32'h11;
    repeat (3) @(negedge clk);
    chk("rst_idex_valid", 64'(bus.idex_valid), 64'd0);
    chk("rst_idex_op1", 64'(bus.idex_op1), 64'd0);
    chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);

    // first edge after reset release must be a normal capture
    @(posedge clk);
    #2 rst = 1'b0;
    s = quiet(); s.id_valid = 1; s.rs1 = 3; s.u1 = 1; s.rd1 = 32'h11; s.rd = 4; s.we = 1;
    s.ctrl = 16'h5A5A;
    apply(s);

    // forwarding priority on rs1=5
    s = quiet(); s.id_valid = 1; s.rs1 = 5; s.u1 = 1; s.rd1 = 32'hD; s.rd = 9; s.we = 1;
    s.ex_valid = 1;  s.ex_we = 1;  s.ex_rd = 5;  s.ex_wd = 32'hA;
    s.mem_valid = 1; s.mem_we = 1; s.mem_rd = 5; s.mem_wd = 32'hB;
    s.wb_valid = 1;  s.wb_we = 1;  s.wb_rd = 5;  s.wb_wd = 32'hC;
    apply(s);
    s.ex_we = 0;  apply(s);
    s.mem_we = 0; apply(s);
    s.wb_we = 0;  apply(s);

    // x0 never forwards
    s = quiet(); s.id_valid = 1; s.rs2 = 0; s.u2 = 1; s.rd2 = 32'h5;
    s.ex_valid = 1; s.ex_we = 1; s.ex_rd = 0; s.ex_wd = 32'hFFFF;
    apply(s);

    // load-use: one bubble, then MEM forwarding supplies the load data
    s = quiet(); s.id_valid = 1; s.rs2 = 7; s.u2 = 1; s.rd2 = 32'h99; s.rd = 8; s.we = 1;
    s.ex_valid = 1; s.ex_we = 1; s.ex_ld = 1; s.ex_rd = 7; s.ex_wd = 32'hDEAD;
    apply(s);
    s.ex_valid = 0; s.ex_ld = 0;
    s.mem_valid = 1; s.mem_we = 1; s.mem_rd = 7; s.mem_wd = 32'h1234;
    apply(s);

    // flush overrides the same hazard
    s = quiet(); s.id_valid = 1; s.rs2 = 7; s.u2 = 1; s.rd = 8; s.we = 1;
    s.ex_valid = 1; s.ex_we = 1; s.ex_ld = 1; s.ex_rd = 7; s.flush = 1;
    apply(s);

    for (int i = 0; i < 300; i++) apply(rand_stim());

    // asynchronous reset in the middle of a cycle kills the slot at once
    s = quiet(); s.id_valid = 1; s.rs1 = 2; s.rd1 = 32'h77; s.rd = 3; s.we = 1;
    apply(s);
    apply(quiet());
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(bus.idex_valid), 64'd0);
    chk("async_rst_cnt", 64'(bus.stall_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_cnt = '0;

    for (int i = 0; i < 200; i++) apply(rand_stim());

    // saturation: preload near the top, then keep stalling
    apply(quiet());
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    s = quiet(); s.id_valid = 1; s.rs1 = 6; s.u1 = 1;
    s.ex_valid = 1; s.ex_we = 1; s.ex_ld = 1; s.ex_rd = 6;
    repeat (3) apply(s);
    s.clr = 1;
    apply(s);
    apply(quiet());

    repeat (3) @(negedge clk);
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
